// File: rtl/sent_tx_crc_engine.sv
// sent_tx_crc_engine: bit-serial SAE J2716 CRC4 / CRC6 engine for the SENT transmitter.
// One message bit per cycle is folded into a shared 6-bit remainder register.
module sent_tx_crc_engine #(
   parameter int MAX_NIBBLES = 6,
   parameter int DATA_W      = 4*MAX_NIBBLES,
   parameter int CNT_W       = $clog2(MAX_NIBBLES+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic              legacy,
   input  logic [CNT_W-1:0]  num_nibbles,
   input  logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              done,
   output logic [5:0]        crc_out,
   output logic              err
);

   localparam int BW = $clog2(4*MAX_NIBBLES+7);

   localparam logic [3:0]       POLY4 = 4'b1101;
   localparam logic [3:0]       SEED4 = 4'b0101;
   localparam logic [5:0]       POLY6 = 6'b011001;
   localparam logic [5:0]       SEED6 = 6'b010101;
   localparam logic [CNT_W-1:0] MAXN  = CNT_W'(MAX_NIBBLES);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic              mode_q;
   logic [DATA_W-1:0] sreg;
   logic [5:0]        rem;
   logic [5:0]        rem_nx;
   logic [BW-1:0]     cnt;
   logic [BW-1:0]     len;
   logic [DATA_W-1:0] keep;
   logic              err_q;
   logic              window;
   logic              req_ok;
   logic              accept;
   logic              reject;
   logic              last;
   logic              bit_in;

   always_comb begin
      window = (state != SHIFT);
      req_ok = mode || ((num_nibbles != '0) && (num_nibbles <= MAXN));
      accept = start && window && req_ok;
      reject = start && window && !req_ok;
      last   = (cnt == BW'(1));
      bit_in = sreg[DATA_W-1];
   end

   // Message length and data mask; bits beyond the payload must shift in as zeros.
   always_comb begin
      len  = '0;
      keep = '0;
      if (mode) begin
         len  = BW'(30);
         keep = ~({DATA_W{1'b1}} >> 24);
      end else begin
         len  = BW'({num_nibbles, 2'b00}) + (legacy ? BW'(0) : BW'(4));
         keep = ~({DATA_W{1'b1}} >> {num_nibbles, 2'b00});
      end
   end

   always_comb begin
      rem_nx = '0;
      if (mode_q) begin
         rem_nx = {rem[4:0], bit_in} ^ (rem[5] ? POLY6 : 6'b0);
      end else begin
         rem_nx = {2'b00, {rem[2:0], bit_in} ^ (rem[3] ? POLY4 : 4'b0)};
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? SHIFT : IDLE;
         SHIFT:   state_nx = last ? DONE : SHIFT;
         DONE:    state_nx = accept ? SHIFT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         mode_q  <= 1'b0;
         sreg    <= '0;
         rem     <= '0;
         cnt     <= '0;
         crc_out <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         err_q <= reject;
         if (accept) begin
            mode_q <= mode;
            sreg   <= data_in & keep;
            rem    <= mode ? SEED6 : {2'b00, SEED4};
            cnt    <= len;
         end else if (state == SHIFT) begin
            sreg <= sreg << 1;
            rem  <= rem_nx;
            cnt  <= cnt - BW'(1);
            if (last) begin
               crc_out <= rem_nx;
            end
         end
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);
   assign err  = err_q;

endmodule

// File: doc/sent_tx_crc_engine.md
Name: sent_tx_crc_engine

Overview:
- Sequential, bit-serial CRC engine for the SENT transmitter.
- Computes the SAE J2716 CRC4 over 1..MAX_NIBBLES fast-channel/short-serial data nibbles, in recommended (zero-nibble augmented) or legacy (non-augmented) form.
- Also computes the CRC6 over the 24-bit enhanced-serial payload.
- Sits between the frame builder and the nibble transmitter; inputs are latched on a start/busy/done handshake, so no combinational long-division loop is needed.

Parameters:
- MAX_NIBBLES, 6, maximum data nibbles per CRC4 frame; must be >= 6 so CRC6 payload fits.
- DATA_W, 4*MAX_NIBBLES, width of data_in (derived; do not override).
- CNT_W, $clog2(MAX_NIBBLES+1), width of num_nibbles (derived).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  request; accepted when busy==0
- mode  input  1  0 = CRC4 nibble CRC, 1 = CRC6 enhanced serial
- legacy  input  1  CRC4 only: 1 = omit augmentation nibble
- num_nibbles  input  CNT_W  CRC4 nibble count, 1..MAX_NIBBLES
- data_in  input  DATA_W  left-aligned, MSB-first; first nibble = data_in[DATA_W-1 -: 4]; CRC6 uses data_in[DATA_W-1 -: 24]
- busy  output  1  computation in progress
- done  output  1  one-cycle pulse, crc_out valid
- crc_out  output  6  result; CRC4 zero-extended in [3:0]; held until next accepted start
- err  output  1  one-cycle pulse, start rejected (bad num_nibbles)

Behaviour:
- Reset (synchronous, active-high) clears everything: busy=0, done=0, err=0, crc_out=0, internal remainder/counter=0. Reset mid-computation aborts it; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start && valid → latch mode, legacy, num_nibbles, data_in; load remainder with the seed; go to SHIFT.
  - Seeds: CRC4 = 4'b0101; CRC6 = 6'b010101.
  - Inputs changing while busy are ignored.
- Validity / rejection:
  - CRC4 with num_nibbles==0 or >MAX_NIBBLES → err=1 for one cycle, stay IDLE, crc_out unchanged.
  - mode=1 ignores num_nibbles and legacy.
- SHIFT: one bit per cycle, MSB first.
  - fb = rem[W-1]; rem <= {rem[W-2:0], bit} ^ (fb ? POLY_LOW : 0).
  - CRC4: W=4, POLY_LOW=4'b1101 (x^4+x^3+x^2+1).
  - CRC6: W=6, POLY_LOW=6'b011001 (x^6+x^4+x^3+1).
  - Bit stream: data bits, then augmentation zeros.
  - Length L: CRC4 recommended = 4*num_nibbles+4; CRC4 legacy = 4*num_nibbles; CRC6 = 24+6 = 30.
  - Result equals long division of {seed, data, zeros} by the polynomial.
- DONE: crc_out <= rem (zero-extended), done=1 for exactly one cycle, busy=0, then IDLE.
- Timing:
  - Start accepted in cycle T.
  - busy=1 during cycles T+1..T+L.
  - done=1 and crc_out updated in cycle T+L+1, with busy=0.
- Back-to-back: start asserted during the DONE cycle is accepted, giving zero idle gap. Throughput is one CRC per L+1 cycles.
- start while busy==1 is ignored: no err, no effect.
- busy and done are never both high.
- crc_out is stable at all times except the DONE-cycle update.
- Internal bit counter width is $clog2(4*MAX_NIBBLES+7); no wrap within a frame.

Test Plan:
- Reset, then mode=0, legacy=0, num_nibbles=3, data_in top 12 bits=0x000, start → busy for 16 cycles, done at T+17, crc_out=0x09.
- Same data with legacy=1 → busy 12 cycles, done at T+13, crc_out=0x06. num_nibbles=6 all-zero, legacy=0 → 28 cycles, crc_out=0x05.
- mode=0, legacy=0, num_nibbles=1, first nibble=0xF → 8 cycles, crc_out=0x0F. Follow with a second start in the DONE cycle (num_nibbles=1, nibble 0x0) → accepted immediately, crc_out=0x0A.
- mode=1, 24-bit payload 0x000000 → 30 busy cycles, crc_out=0x26. Toggle data_in while busy → result unchanged.
- num_nibbles=0 and num_nibbles=MAX_NIBBLES+1 with mode=0 → single-cycle err, busy stays 0, crc_out keeps previous value. start while busy → ignored, no err.
- Assert reset at cycle T+5 of a CRC6 job → next cycle busy=0, crc_out=0, no done pulse. A fresh start afterwards produces correct 0x26.
